// File: rtl/mult_sec_arb.sv
// Round-robin front end that shares one sequential shift-add multiplier between
// NUM_REQ clients. It holds the operands for the whole multiply and abandons a hung operation.
module mult_sec_arb #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 100,
  parameter int TO_W    = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*32-1:0] req_mplier,
  input  logic [NUM_REQ*32-1:0] req_mcand,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [63:0]           rsp_product,
  output logic                  rsp_err,
  output logic                  mul_st,
  output logic [31:0]           mul_mplier,
  output logic [31:0]           mul_mcand,
  input  logic                  mul_done,
  input  logic [63:0]           mul_product
);

  typedef enum logic [1:0] {IDLE, START, BUSY, RESP} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [31:0]       op_mplier_q, op_mplier_d;
  logic [31:0]       op_mcand_q, op_mcand_d;
  logic [63:0]       product_q, product_d;
  logic              err_q, err_d;
  logic [TO_W-1:0]   wdog_q, wdog_d;

  logic              grant_found;
  logic [ID_W-1:0]   grant_idx;
  int                grant_int;
  int                cand;

  // Search starts just past the last winner, so the requester just served ranks last.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    grant_int   = 0;
    cand        = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_int   = cand;
        grant_idx   = ID_W'(cand);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && grant_found && !rst) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    id_d        = id_q;
    op_mplier_d = op_mplier_q;
    op_mcand_d  = op_mcand_q;
    product_d   = product_q;
    err_d       = err_q;
    wdog_d      = wdog_q;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          op_mplier_d = req_mplier[grant_int*32 +: 32];
          op_mcand_d  = req_mcand[grant_int*32 +: 32];
          id_d        = grant_idx;
          rr_ptr_d    = grant_idx;
          state_d     = START;
        end
      end
      START: begin
        wdog_d  = '0;
        state_d = BUSY;
      end
      BUSY: begin
        wdog_d = wdog_q + TO_W'(1);
        // A done arriving on the final watchdog cycle still counts as a good result.
        if (mul_done) begin
          product_d = mul_product;
          err_d     = 1'b0;
          state_d   = RESP;
        end else if (wdog_q == TO_W'(TIMEOUT - 1)) begin
          product_d = '0;
          err_d     = 1'b1;
          state_d   = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= ID_W'(NUM_REQ - 1);
      id_q        <= '0;
      op_mplier_q <= '0;
      op_mcand_q  <= '0;
      product_q   <= '0;
      err_q       <= 1'b0;
      wdog_q      <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      id_q        <= id_d;
      op_mplier_q <= op_mplier_d;
      op_mcand_q  <= op_mcand_d;
      product_q   <= product_d;
      err_q       <= err_d;
      wdog_q      <= wdog_d;
    end
  end

  // The multiplier re-reads mcand every add cycle, so operands stay on the bus until IDLE.
  assign mul_st      = (state_q == START);
  assign mul_mplier  = (state_q != IDLE) ? op_mplier_q : '0;
  assign mul_mcand   = (state_q != IDLE) ? op_mcand_q : '0;
  assign rsp_valid   = (state_q == RESP);
  assign rsp_id      = id_q;
  assign rsp_product = product_q;
  assign rsp_err     = err_q;

endmodule

// File: tb/tb_mult_sec_arb.sv
// Bench for mult_sec_arb: behavioural multiplier model, queue-based scoreboard,
// a table of directed vectors, corner-case sequences and a randomized phase.
module tb_mult_sec_arb;

  localparam int N   = 4;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*32-1:0] req_mplier;
  logic [N*32-1:0] req_mcand;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [IDW-1:0] rsp_id;
  logic [63:0]    rsp_product;
  logic           rsp_err;
  logic           mul_st;
  logic [31:0]    mul_mplier;
  logic [31:0]    mul_mcand;
  logic           mul_done;
  logic [63:0]    mul_product;

  always #5 clk = ~clk;

  mult_sec_arb #(.NUM_REQ(N), .ID_W(IDW), .TIMEOUT(100), .TO_W(7)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_mplier(req_mplier), .req_mcand(req_mcand),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_product(rsp_product), .rsp_err(rsp_err),
    .mul_st(mul_st), .mul_mplier(mul_mplier), .mul_mcand(mul_mcand),
    .mul_done(mul_done), .mul_product(mul_product)
  );

  int checks = 0;
  int errors = 0;

  function automatic int pop32(input logic [31:0] v);
    int c;
    c = 0;
    for (int i = 0; i < 32; i++) c += int'(v[i]);
    return c;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Multiplier model: done pulses 33+popcount cycles after st; not touched by rst.
  int          rem = 0;
  logic [31:0] m_a = '0;
  logic        hang = 1'b0;

  always @(posedge clk) begin
    if (mul_st) begin
      rem <= 33 + pop32(mul_mplier);
      m_a <= mul_mplier;
    end else if (rem > 0) begin
      rem <= rem - 1;
    end
  end

  assign mul_done    = (rem == 1) && !hang;
  assign mul_product = mul_done ? ({32'b0, m_a} * {32'b0, mul_mcand}) : 64'hDEAD_BEEF_DEAD_BEEF;

  // Scoreboard: one outstanding operation at a time, round-robin from the last grant.
  typedef struct {
    int          id;
    logic [63:0] prod;
    logic        err;
  } exp_t;

  exp_t         exp_q[$];
  exp_t         mon_e;
  int           last_grant = N - 1;
  int           mon_g;
  logic         mon_busy;
  logic [N-1:0] mon_rdy;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      last_grant = N - 1;
    end else begin
      mon_busy = (exp_q.size() != 0);
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          checkOutput("spurious_rsp", 64'(rsp_valid), 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          checkOutput("rsp_id", 64'(rsp_id), 64'(mon_e.id));
          checkOutput("rsp_product", rsp_product, mon_e.prod);
          checkOutput("rsp_err", 64'(rsp_err), 64'(mon_e.err));
        end
      end else if (!mon_busy) begin
        checkOutput("rsp_idle", 64'(rsp_valid), 64'd0);
      end
      if (mon_busy) begin
        checkOutput("ready_while_busy", 64'(req_ready), 64'd0);
      end else begin
        mon_g   = -1;
        mon_rdy = '0;
        for (int k = 1; k <= N; k++) begin
          if (mon_g < 0 && req_valid[(last_grant + k) % N]) mon_g = (last_grant + k) % N;
        end
        if (mon_g >= 0) mon_rdy[mon_g] = 1'b1;
        checkOutput("grant", 64'(req_ready), 64'(mon_rdy));
        if (mon_g >= 0) begin
          mon_e.id   = mon_g;
          mon_e.err  = hang;
          mon_e.prod = hang ? 64'd0 :
                       ({32'b0, req_mplier[mon_g*32 +: 32]} * {32'b0, req_mcand[mon_g*32 +: 32]});
          exp_q.push_back(mon_e);
          last_grant = mon_g;
        end
      end
    end
  end

  // Issues one request and returns the response plus cycles from START to rsp_valid.
  task automatic applyStimulus(input int id, input logic [31:0] a, input logic [31:0] b,
                               output logic [63:0] prod, output logic [IDW-1:0] rid,
                               output logic err, output int dly);
    int   n;
    logic stable;
    @(posedge clk); #1;
    req_mplier[id*32 +: 32] = a;
    req_mcand[id*32 +: 32]  = b;
    req_valid[id]           = 1'b1;
    n = 0;
    @(negedge clk);
    while (!req_ready[id] && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) checkOutput("accept_wait", 64'(n), 64'd0);
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
    @(negedge clk);
    checkOutput("st_pulse", 64'(mul_st), 64'd1);
    checkOutput("st_mplier", 64'(mul_mplier), 64'(a));
    stable = 1'b1;
    dly    = 0;
    while (!rsp_valid && dly < 300) begin
      @(negedge clk);
      dly++;
      if (dly == 1) checkOutput("st_one_cycle", 64'(mul_st), 64'd0);
      if (mul_mcand !== b) stable = 1'b0;
    end
    checkOutput("mcand_stable", 64'(stable), 64'd1);
    prod = rsp_product;
    rid  = rsp_id;
    err  = rsp_err;
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain", 64'(exp_q.size()), 64'd0);
  endtask

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] prod;
    int          dly;
  } vec_t;

  vec_t           vecs[5];
  logic [63:0]    r_prod;
  logic [63:0]    hold_prod;
  logic [IDW-1:0] r_id;
  logic           r_err;
  int             r_dly;
  int             order[$];
  int             n_wait;
  int             late;
  int             served;
  int             cyc;
  logic [N-1:0]   acc;

  initial begin
    vecs[0] = '{0, 32'd3,          32'd5,          64'd15,                  36};
    vecs[1] = '{2, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001, 66};
    vecs[2] = '{1, 32'd0,          32'h1234_5678,  64'd0,                   34};
    vecs[3] = '{3, 32'h8000_0000,  32'd2,          64'h1_0000_0000,         35};
    vecs[4] = '{1, 32'h0000_FFFF,  32'h0001_0001,  64'hFFFF_FFFF,           50};

    rst        = 1'b1;
    req_valid  = '1;
    req_mplier = '0;
    req_mcand  = '0;
    rsp_ready  = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_req_ready", 64'(req_ready), 64'd0);
    checkOutput("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("rst_rsp_id", 64'(rsp_id), 64'd0);
    checkOutput("rst_rsp_product", rsp_product, 64'd0);
    checkOutput("rst_rsp_err", 64'(rsp_err), 64'd0);
    checkOutput("rst_mul_st", 64'(mul_st), 64'd0);
    checkOutput("rst_mul_mplier", 64'(mul_mplier), 64'd0);
    checkOutput("rst_mul_mcand", 64'(mul_mcand), 64'd0);
    @(posedge clk); #1;
    req_valid = '0;
    rst       = 1'b0;
    rsp_ready = 1'b1;

    for (int v = 0; v < 5; v++) begin
      applyStimulus(vecs[v].id, vecs[v].a, vecs[v].b, r_prod, r_id, r_err, r_dly);
      checkOutput("tbl_product", r_prod, vecs[v].prod);
      checkOutput("tbl_id", 64'(r_id), 64'(vecs[v].id));
      checkOutput("tbl_err", 64'(r_err), 64'd0);
      checkOutput("tbl_latency", 64'(r_dly), 64'(vecs[v].dly));
    end

    // All four requesters held valid: grants must rotate 0,1,2,3,0 after reset.
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      req_mplier[i*32 +: 32] = 32'(i + 2);
      req_mcand[i*32 +: 32]  = 32'(100 + i);
    end
    req_valid = '1;
    n_wait = 0;
    while (order.size() < 5 && n_wait < 600) begin
      @(negedge clk);
      n_wait++;
      for (int i = 0; i < N; i++) if (req_ready[i]) order.push_back(i);
    end
    @(posedge clk); #1;
    req_valid = '0;
    waitIdle();
    checkOutput("rr_count", 64'(order.size()), 64'd5);
    for (int k = 0; k < order.size(); k++) checkOutput("rr_order", 64'(order[k]), 64'(k % N));

    // Response back-pressure: data held, no new accept until the handshake.
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    req_mplier[1*32 +: 32] = 32'h1234;
    req_mcand[1*32 +: 32]  = 32'h10;
    req_valid[1]           = 1'b1;
    n_wait = 0;
    @(negedge clk);
    while (!req_ready[1] && n_wait < 300) begin
      @(negedge clk);
      n_wait++;
    end
    @(posedge clk); #1;
    req_valid[1]           = 1'b0;
    req_mplier[3*32 +: 32] = 32'd7;
    req_mcand[3*32 +: 32]  = 32'd11;
    req_valid[3]           = 1'b1;
    n_wait = 0;
    while (!rsp_valid && n_wait < 300) begin
      @(negedge clk);
      n_wait++;
    end
    hold_prod = rsp_product;
    checkOutput("bp_product", hold_prod, 64'h12340);
    repeat (20) begin
      @(negedge clk);
      checkOutput("bp_valid_held", 64'(rsp_valid), 64'd1);
      checkOutput("bp_product_held", rsp_product, hold_prod);
      checkOutput("bp_id_held", 64'(rsp_id), 64'd1);
      checkOutput("bp_no_accept", 64'(req_ready), 64'd0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("bp_next_accept", 64'(req_ready), 64'b1000);
    @(posedge clk); #1;
    req_valid[3] = 1'b0;
    waitIdle();

    // Multiplier never answers: watchdog must abandon after 100 BUSY cycles.
    hang = 1'b1;
    applyStimulus(0, 32'd7, 32'd9, r_prod, r_id, r_err, r_dly);
    hang = 1'b0;
    checkOutput("to_latency", 64'(r_dly), 64'd101);
    checkOutput("to_err", 64'(r_err), 64'd1);
    checkOutput("to_product", r_prod, 64'd0);
    applyStimulus(2, 32'd1000, 32'd1000, r_prod, r_id, r_err, r_dly);
    checkOutput("after_to_product", r_prod, 64'd1000000);
    checkOutput("after_to_err", 64'(r_err), 64'd0);
    checkOutput("after_to_latency", 64'(r_dly), 64'(34 + pop32(32'd1000)));

    // Reset ten cycles into BUSY; the multiplier's late done must be ignored.
    @(posedge clk); #1;
    req_mplier[2*32 +: 32] = 32'hFFFF_FFFF;
    req_mcand[2*32 +: 32]  = 32'd3;
    req_valid[2]           = 1'b1;
    n_wait = 0;
    @(negedge clk);
    while (!req_ready[2] && n_wait < 300) begin
      @(negedge clk);
      n_wait++;
    end
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("mid_rst_mul_st", 64'(mul_st), 64'd0);
    checkOutput("mid_rst_mplier", 64'(mul_mplier), 64'd0);
    checkOutput("mid_rst_mcand", 64'(mul_mcand), 64'd0);
    checkOutput("mid_rst_product", rsp_product, 64'd0);
    checkOutput("mid_rst_id", 64'(rsp_id), 64'd0);
    checkOutput("mid_rst_err", 64'(rsp_err), 64'd0);
    @(posedge clk); #1;
    rst  = 1'b0;
    late = 0;
    repeat (66) begin
      @(negedge clk);
      if (rsp_valid) late++;
    end
    checkOutput("late_done_ignored", 64'(late), 64'd0);
    applyStimulus(1, 32'd6, 32'd7, r_prod, r_id, r_err, r_dly);
    checkOutput("after_rst_product", r_prod, 64'd42);
    checkOutput("after_rst_id", 64'(r_id), 64'd1);
    checkOutput("after_rst_latency", 64'(r_dly), 64'd36);

    // Randomized traffic against the scoreboard.
    served = 0;
    cyc    = 0;
    while (served < 30 && cyc < 8000) begin
      @(negedge clk);
      acc = req_ready & req_valid;
      if (rsp_valid && rsp_ready) served++;
      @(posedge clk); #1;
      cyc++;
      req_valid = req_valid & ~acc;
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(3) == 0) begin
          req_mplier[i*32 +: 32] = $urandom;
          req_mcand[i*32 +: 32]  = $urandom;
          req_valid[i]           = 1'b1;
        end
      end
      rsp_ready = ($urandom_range(3) != 0);
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    waitIdle();
    checkOutput("rand_served", 64'(served >= 30), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
